// File: rtl/menu_overlay.sv
// Start-menu layer: stacked selectable boxes, debounced cursor buttons,
// select flash, then a one-cycle start pulse to the game controller.
//
// state   | meaning
// IDLE    | layer off, RGB 0, waiting for enable
// MENU    | boxes drawn, up/down move cursor, select confirms
// CONFIRM | chosen box flashes once per frame, start pulses when done
module menu_overlay #(
  parameter int          ITEMS           = 3,
  parameter int          H_ACTIVE        = 640,
  parameter int          V_ACTIVE        = 480,
  parameter int          ITEM_X          = 220,
  parameter int          ITEM_W          = 200,
  parameter int          ITEM_Y0         = 140,
  parameter int          ITEM_H          = 40,
  parameter int          ITEM_GAP        = 20,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          FLASH_FRAMES    = 16,
  parameter logic [7:0]  BG_COLOR        = 8'h02,
  parameter logic [7:0]  ITEM_COLOR      = 8'h92,
  parameter logic [7:0]  SEL_COLOR       = 8'hFC
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [9:0]                 hcount,
  input  logic [9:0]                 vcount,
  input  logic                       enable,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_select,
  output logic [2:0]                 red,
  output logic [2:0]                 green,
  output logic [1:0]                 blue,
  output logic                       layer,
  output logic [$clog2(ITEMS)-1:0]   selection,
  output logic                       start
);

  localparam int SW = $clog2(ITEMS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [CW-1:0] DB_LIMIT   = CW'(DEBOUNCE_CYCLES);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [SW-1:0] SEL_MAX    = SW'(ITEMS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MENU, S_CONFIRM} state_t;

  // button index: 0 up, 1 down, 2 select
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    press_q, press_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [FW-1:0] flash_q, flash_d;
  logic          phase_q, phase_d;
  logic          start_q, start_d;
  logic [7:0]    pix_q, pix_d;
  logic          layer_q, layer_d;

  logic          frame_start;
  logic          hit;
  logic [SW-1:0] hit_idx;
  logic [10:0]   hc11, vc11;

  assign btn_raw     = {btn_select, btn_down, btn_up};
  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  assign hc11        = {1'b0, hcount};
  assign vc11        = {1'b0, vcount};

  function automatic logic [10:0] item_top(input int i);
    return 11'(ITEM_Y0 + i * (ITEM_H + ITEM_GAP));
  endfunction

  // Debounce: accept a new level after DEBOUNCE_CYCLES mismatching cycles; strobe on rising accept
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int b = 0; b < 3; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DB_LIMIT) begin
          deb_d[b]   = sync2_q[b];
          press_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Next-state logic: cursor movement, confirm flash counting, start pulse
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    flash_d = flash_q;
    phase_d = phase_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_MENU;
      end
      S_MENU: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (press_q[2]) begin
          state_d = S_CONFIRM;
          flash_d = '0;
          phase_d = 1'b1;
        end else if (press_q[0] && !press_q[1]) begin
          sel_d = (sel_q == '0) ? SEL_MAX : sel_q - 1'b1;
        end else if (press_q[1] && !press_q[0]) begin
          sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + 1'b1;
        end
      end
      S_CONFIRM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (frame_start) begin
          phase_d = ~phase_q;
          flash_d = flash_q + 1'b1;
          if (flash_q == FLASH_LAST) begin
            start_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pixel colour for the current hcount/vcount, registered one cycle later
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ITEMS; i++) begin
      if (hc11 >= 11'(ITEM_X) && hc11 < 11'(ITEM_X + ITEM_W) &&
          vc11 >= item_top(i) && vc11 < item_top(i) + 11'(ITEM_H)) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
    layer_d = (state_q != S_IDLE);
    if (state_q == S_IDLE || hc11 >= 11'(H_ACTIVE) || vc11 >= 11'(V_ACTIVE)) begin
      pix_d = 8'h00;
    end else if (hit && hit_idx == sel_q) begin
      pix_d = (state_q == S_CONFIRM && !phase_q) ? BG_COLOR : SEL_COLOR;
    end else if (hit) begin
      pix_d = ITEM_COLOR;
    end else begin
      pix_d = BG_COLOR;
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int b = 0; b < 3; b++) cnt_q[b] <= '0;
      state_q <= S_IDLE;
      sel_q   <= '0;
      flash_q <= '0;
      phase_q <= 1'b0;
      start_q <= 1'b0;
      pix_q   <= '0;
      layer_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int b = 0; b < 3; b++) cnt_q[b] <= cnt_d[b];
      state_q <= state_d;
      sel_q   <= sel_d;
      flash_q <= flash_d;
      phase_q <= phase_d;
      start_q <= start_d;
      pix_q   <= pix_d;
      layer_q <= layer_d;
    end
  end

  assign {red, green, blue} = pix_q;
  assign layer              = layer_q;
  assign selection          = sel_q;
  assign start              = start_q;

endmodule

// File: tb/tb_menu_overlay.sv
// Bench for menu_overlay: directed sequence with random pixel sweeps
// compared against a rule-based model of the menu picture.
module tb_menu_overlay;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] hcount, vcount;
  logic       enable, btn_up, btn_down, btn_select;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       layer, start;
  logic [1:0] selection;

  int vectors = 0;
  int miscompares = 0;

  localparam int M_IDLE = 0, M_MENU = 1, M_CONF = 2;
  int m_sel  = 0;
  int m_mode = M_IDLE;
  bit m_phase = 1'b1;

  menu_overlay #(.ITEMS(3), .DEBOUNCE_CYCLES(4), .FLASH_FRAMES(2)) dut (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .enable(enable), .btn_up(btn_up), .btn_down(btn_down), .btn_select(btn_select),
    .red(red), .green(green), .blue(blue), .layer(layer),
    .selection(selection), .start(start)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] exp_pix(input int h, input int v);
    int d, idx;
    if (m_mode == M_IDLE) return 8'h00;
    if (h >= 640 || v >= 480) return 8'h00;
    if (h >= 220 && h < 420 && v >= 140) begin
      d   = v - 140;
      idx = d / 60;
      if (idx < 3 && (d % 60) < 40) begin
        if (idx == m_sel) return (m_mode == M_CONF && !m_phase) ? 8'h02 : 8'hFC;
        return 8'h92;
      end
    end
    return 8'h02;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int h, input int v, input string tag);
    hcount = 10'(h);
    vcount = 10'(v);
    step();
    chk(tag, 32'({red, green, blue}), 32'(exp_pix(h, v)));
    chk({tag, "_layer"}, 32'(layer), 32'(m_mode != M_IDLE));
  endtask

  task automatic rand_pix(input int n, input string tag);
    int h, v;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        h = $urandom_range(200, 440);
        v = $urandom_range(120, 340);
      end else begin
        h = $urandom_range(0, 1023);
        v = $urandom_range(0, 1023);
      end
      if (h == 0 && v == 0) h = 5;
      pix(h, v, tag);
    end
  endtask

  // clean press: level held 8 cycles, selection checked one edge before and at the update edge
  task automatic press(input bit up, input bit dn, input bit sl, input int exp_sel);
    btn_up = up; btn_down = dn; btn_select = sl;
    repeat (7) step();
    chk("press_before", 32'(selection), 32'(m_sel));
    step();
    chk("press_update", 32'(selection), 32'(exp_sel));
    m_sel = exp_sel;
    btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
    repeat (8) step();
    chk("press_release", 32'(selection), 32'(m_sel));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
    hcount = 10'd0; vcount = 10'd0;
    repeat (3) step();
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_layer", 32'(layer), 32'h0);
    chk("rst_sel", 32'(selection), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    reset = 1'b0;
    step();

    // idle: nothing drawn
    rand_pix(40, "idle");
    chk("idle_sel", 32'(selection), 32'h0);

    // enable rise: MENU at edge e, colour at e+1
    enable = 1'b1;
    step();
    m_mode = M_MENU;
    pix(300, 150, "render_sel");
    pix(300, 210, "render_item");
    pix(300, 190, "render_gap");
    pix(700, 150, "render_offscreen");
    pix(219, 150, "render_left_edge");
    pix(419, 179, "render_last_px");
    pix(420, 150, "render_right_edge");
    rand_pix(60, "menu_rand");

    // bouncing down button never settles
    for (int g = 0; g < 4; g++) begin
      btn_down = 1'b1;
      repeat (3) step();
      btn_down = 1'b0;
      step();
      chk("glitch_sel", 32'(selection), 32'(m_sel));
    end
    // held 10 cycles: moves exactly 7 edges after first stable sample
    btn_down = 1'b1;
    repeat (7) step();
    chk("deb_edge6", 32'(selection), 32'h0);
    step();
    chk("deb_edge7", 32'(selection), 32'h1);
    m_sel = 1;
    repeat (2) step();
    btn_down = 1'b0;
    repeat (8) step();
    chk("deb_release", 32'(selection), 32'h1);

    // wrap-around and simultaneous up/down
    press(1, 0, 0, 0);
    press(1, 0, 0, 2);
    rand_pix(20, "sel2_rand");
    press(0, 1, 0, 0);
    press(1, 1, 0, 0);
    press(0, 1, 0, 1);
    rand_pix(20, "sel1_rand");

    // confirm with flash, buttons ignored, start after 2nd frame start
    hcount = 10'd300; vcount = 10'd210;
    press(0, 0, 1, 1);
    m_mode = M_CONF; m_phase = 1'b1;
    pix(300, 210, "conf_on");
    press(1, 0, 0, 1);
    press(0, 1, 0, 1);
    rand_pix(10, "conf_on_rand");
    hcount = 10'd0; vcount = 10'd0;
    step();
    chk("start_early", 32'(start), 32'h0);
    m_phase = 1'b0;
    pix(300, 210, "conf_off");
    rand_pix(10, "conf_off_rand");
    hcount = 10'd0; vcount = 10'd0;
    step();
    chk("start_pulse", 32'(start), 32'h1);
    chk("start_sel", 32'(selection), 32'h1);
    enable = 1'b0;
    m_mode = M_IDLE;
    hcount = 10'd300; vcount = 10'd210;
    step();
    chk("start_one_cycle", 32'(start), 32'h0);
    chk("post_start_layer", 32'(layer), 32'h0);
    chk("post_start_rgb", 32'({red, green, blue}), 32'h0);

    // abort confirm by dropping enable
    enable = 1'b1;
    step();
    m_mode = M_MENU;
    pix(300, 210, "abort_menu");
    press(0, 0, 1, 1);
    m_mode = M_CONF; m_phase = 1'b1;
    pix(300, 210, "abort_conf");
    enable = 1'b0;
    step();
    m_mode = M_IDLE;
    for (int f = 0; f < 4; f++) begin
      hcount = 10'd0; vcount = 10'd0;
      step();
      chk("abort_nostart", 32'(start), 32'h0);
      chk("abort_rgb", 32'({red, green, blue}), 32'h0);
      chk("abort_layer", 32'(layer), 32'h0);
    end
    enable = 1'b1;
    step();
    m_mode = M_MENU;
    chk("reenable_sel", 32'(selection), 32'h1);
    pix(300, 210, "reenable_pix");

    // asynchronous reset in the middle of CONFIRM
    press(0, 0, 1, 1);
    m_mode = M_CONF; m_phase = 1'b1;
    pix(300, 210, "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    chk("areset_rgb", 32'({red, green, blue}), 32'h0);
    chk("areset_layer", 32'(layer), 32'h0);
    chk("areset_sel", 32'(selection), 32'h0);
    chk("areset_start", 32'(start), 32'h0);
    m_sel = 0; m_mode = M_IDLE;
    enable = 1'b0;
    step();
    reset = 1'b0;
    step();
    rand_pix(10, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/menu_overlay.md
# menu_overlay

Parametrised start-menu layer for the Pong VGA pipeline: draws ITEMS stacked selectable boxes over a background, tracks a cursor driven by debounced up/down/select buttons, and flashes the chosen item before emitting a one-cycle `start` pulse to the game controller. It sits beside the other layers feeding the RGB priority mux, driven by the shared `hcount`/`vcount` counters. It is a sequential successor to the fixed single-colour menu layer.

## Interface
- `ITEMS`, 3: number of menu entries (2..8); `SW = $clog2(ITEMS)`.
- `H_ACTIVE`, 640; `V_ACTIVE`, 480: visible area.
- `ITEM_X`, 220; `ITEM_W`, 200: item column left edge and width.
- `ITEM_Y0`, 140; `ITEM_H`, 40; `ITEM_GAP`, 20: first item top, item height, vertical gap.
- `DEBOUNCE_CYCLES`, 250000: stable cycles required before a button level is accepted.
- `FLASH_FRAMES`, 16: frames the selected item flashes after select.
- `BG_COLOR`, 8'h02; `ITEM_COLOR`, 8'h92; `SEL_COLOR`, 8'hFC: colours as RRRGGGBB.
- `clock` input 1: pixel clock.
- `reset` input 1: asynchronous, active-high.
- `hcount` input 10: current pixel column.
- `vcount` input 10: current pixel row.
- `enable` input 1: menu requested by the top-level.
- `btn_up`, `btn_down`, `btn_select` input 1 each: raw asynchronous button levels, active-high.
- `red` output 3, `green` output 3, `blue` output 2: registered pixel colour.
- `layer` output 1: this layer owns the pixel (high whenever state != IDLE).
- `selection` output SW: current cursor index.
- `start` output 1: one-cycle pulse, chosen index valid on `selection`.

## Operation
- Button path, per button: 2-flop synchroniser -> counter compared to `DEBOUNCE_CYCLES`; the debounced level changes only after the synchronised level differs from it for `DEBOUNCE_CYCLES` consecutive cycles (counter clears on any bounce). A rising edge of the debounced level produces a one-cycle `press` strobe.
- States: IDLE, MENU, CONFIRM.
  - IDLE: RGB 0, `layer` 0. `enable` high -> MENU.
  - MENU: up press: `selection` decrements, 0 wraps to ITEMS-1. Down press: increments, ITEMS-1 wraps to 0. Up and down in the same cycle: no change. Select press (wins over up/down in the same cycle) -> CONFIRM, flash counter cleared, flash phase = on.
  - CONFIRM: up/down/select ignored. At each frame start (`hcount==0 && vcount==0`) the flash phase toggles and the counter increments; when the counter reaches `FLASH_FRAMES`, `start` pulses for one cycle and the state returns to IDLE.
  - `enable` low in MENU or CONFIRM -> IDLE next cycle, no `start`. `selection` is retained across IDLE; only `reset` clears it.
- Pixel rule, evaluated from the current `hcount`/`vcount`:
  - If `hcount>=H_ACTIVE` or `vcount>=V_ACTIVE`: 0.
  - Item i is hit when `ITEM_X <= hcount < ITEM_X+ITEM_W` and `Yi <= vcount < Yi+ITEM_H`, where `Yi = ITEM_Y0 + i*(ITEM_H+ITEM_GAP)`. Compute at 11 bits, no overflow.
  - Hit on item == `selection`: `SEL_COLOR` (in CONFIRM: `SEL_COLOR` when phase on, `BG_COLOR` when off).
  - Hit on any other item: `ITEM_COLOR`.
  - Otherwise: `BG_COLOR`.
- Reset values: state IDLE, `selection` 0, `start` 0, `layer` 0, RGB 0, debounced levels 0, counters 0.

## Timing
- RGB and `layer` are registered: 1-cycle latency from `hcount`/`vcount` to colour.
- A clean press asserted before edge t reaches the debounced level at edge t+2+DEBOUNCE_CYCLES. The `press` strobe is high for the following cycle, and `selection` or state updates at edge t+3+DEBOUNCE_CYCLES.
- Entry to CONFIRM at edge c; `start` high during the cycle after the FLASH_FRAMES-th frame-start edge; IDLE at the same edge.
- `enable` rise at edge e: state MENU at e; first coloured pixel registered at e+1.
- Asynchronous reset mid-frame or mid-CONFIRM forces all reset values immediately; no `start`.

## Test plan
- Reset/idle: `reset` high then low, `enable`=0, sweep a frame -> RGB 0, `layer` 0, `selection` 0 throughout.
- Render (ITEMS=3, defaults): `enable`=1, sample pixels -> (300,150)=8'hFC, (300,210)=8'h92, (300,190)=8'h02, (700,150)=0.
- Debounce (DEBOUNCE_CYCLES=4): `btn_down` glitches 3 cycles high/1 low repeatedly -> `selection` stays 0; then held 10 cycles -> `selection`=1 exactly 7 edges after the first stable sample.
- Wrap: from 0 press up -> 2; press down -> 0; up+down in the same cycle -> unchanged.
- Confirm (FLASH_FRAMES=2): select on index 1 -> item 1 alternates 8'h02/8'hFC per frame, buttons ignored, `start` high exactly one cycle after the 2nd frame start with `selection`=1, `layer`->0.
- Abort: drop `enable` during CONFIRM -> IDLE next edge, no `start`; re-enable -> `selection` still 1.
